// File: rtl/shift_vec_ctrl.sv
// Sequences one external 32-bit shifter across LANES vector elements, one lane per cycle,
// collecting results into vec_out and pulsing done when the whole vector is complete.
module shift_vec_ctrl #(
  parameter int unsigned LANES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LANES*32-1:0]   vec_in,
  input  logic [LANES-1:0]      lane_mask,
  input  logic [4:0]            shift_amount,
  input  logic [1:0]            type_op,
  output logic [31:0]           sh_in,
  output logic [4:0]            sh_amount,
  output logic [1:0]            sh_type,
  input  logic [31:0]           sh_out,
  output logic                  busy,
  output logic                  done,
  output logic [LANES*32-1:0]   vec_out
);

  localparam int unsigned IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [LANES*32-1:0]   vec_q, vec_d;
  logic [LANES-1:0]      mask_q, mask_d;
  logic [4:0]            amt_q, amt_d;
  logic [1:0]            type_q, type_d;
  logic [LANES*32-1:0]   res_q, res_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [31:0]           lane_cur;

  assign lane_cur = vec_q[idx_q*32 +: 32];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vec_d     = vec_q;
    mask_d    = mask_q;
    amt_d     = amt_q;
    type_d    = type_q;
    res_d     = res_q;
    sh_in     = '0;
    sh_amount = '0;
    sh_type   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d   = vec_in;
          mask_d  = lane_mask;
          amt_d   = shift_amount;
          type_d  = type_op;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sh_in     = lane_cur;
        sh_amount = amt_q;
        sh_type   = type_q;
        // Masked lanes still take a cycle so latency never depends on the mask.
        res_d[idx_q*32 +: 32] = mask_q[idx_q] ? sh_out : lane_cur;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      mask_q  <= '0;
      amt_q   <= '0;
      type_q  <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      amt_q   <= amt_d;
      type_q  <= type_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign vec_out = res_q;

endmodule

// File: tb/tb_shift_vec_ctrl.sv
// Bench for shift_vec_ctrl: directed vectors plus random commands checked against a
// per-lane arithmetic reference; includes a simple behavioural shifter on sh_*.
module tb_shift_vec_ctrl;

  localparam int unsigned LANES = 4;
  localparam int unsigned VW    = LANES * 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [VW-1:0]   vec_in;
  logic [LANES-1:0] lane_mask;
  logic [4:0]      shift_amount;
  logic [1:0]      type_op;
  logic [31:0]     sh_in;
  logic [4:0]      sh_amount;
  logic [1:0]      sh_type;
  logic [31:0]     sh_out;
  logic            busy;
  logic            done;
  logic [VW-1:0]   vec_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  shift_vec_ctrl #(.LANES(LANES)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .vec_in       (vec_in),
    .lane_mask    (lane_mask),
    .shift_amount (shift_amount),
    .type_op      (type_op),
    .sh_in        (sh_in),
    .sh_amount    (sh_amount),
    .sh_type      (sh_type),
    .sh_out       (sh_out),
    .busy         (busy),
    .done         (done),
    .vec_out      (vec_out)
  );

  // External shifter: zero-fill, left only for type 0.
  assign sh_out = (sh_type == 2'b00) ? (sh_in << sh_amount) : (sh_in >> sh_amount);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] ref_result(input logic [VW-1:0] v, input logic [LANES-1:0] m,
                                               input logic [4:0] a, input logic [1:0] t);
    logic [VW-1:0] r;
    logic [31:0]   e;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      e = v[32*i +: 32];
      if (m[i]) e = (t == 2'b00) ? (e << a) : (e >> a);
      r[32*i +: 32] = e;
    end
    return r;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, VW'(busy), VW'(1'b0));
    check({tag, "_done"}, VW'(done), VW'(1'b0));
    check({tag, "_sh"},   VW'({sh_in, sh_amount, sh_type}), '0);
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < LANES; i++) vec_in[32*i +: 32] = $urandom();
    lane_mask    = LANES'($urandom());
    shift_amount = 5'($urandom());
    type_op      = 2'($urandom());
  endtask

  // Called #1 after an edge in IDLE; returns #1 after the edge following the done cycle.
  task automatic run_cmd(input logic [VW-1:0] v, input logic [LANES-1:0] m, input logic [4:0] a,
                         input logic [1:0] t, input bit scramble, input bit poke);
    logic [VW-1:0] exp;
    exp          = ref_result(v, m, a, t);
    vec_in       = v;
    lane_mask    = m;
    shift_amount = a;
    type_op      = t;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= LANES + 1; c++) begin
      check("busy", VW'(busy), VW'(1'b1));
      check("done", VW'(done), VW'(c == LANES + 1));
      if (c <= LANES) begin
        check("sh_in",     VW'(sh_in),     VW'(v[32*(c-1) +: 32]));
        check("sh_amount", VW'(sh_amount), VW'(a));
        check("sh_type",   VW'(sh_type),   VW'(t));
      end else begin
        check("vec_done", vec_out, exp);
        check("sh_done",  VW'({sh_in, sh_amount, sh_type}), '0);
      end
      if (scramble) randomize_inputs();
      if (poke && (c == 2 || c == LANES + 1)) begin
        vec_in       = ~v;
        lane_mask    = ~m;
        shift_amount = a + 5'd3;
        type_op      = ~t;
        start        = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_quiet("idle");
    check("vec_hold", vec_out, exp);
  endtask

  logic [VW-1:0] v1;
  logic [VW-1:0] vall;

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    vec_in       = '0;
    lane_mask    = '0;
    shift_amount = '0;
    type_op      = '0;
    #1;
    check_quiet("rst");
    check("rst_vec", vec_out, '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    v1 = {32'h80000001, 32'h0000FFFF, 32'h12345678, 32'h00000001};
    run_cmd(v1, 4'b1111, 5'd4, 2'b00, 1'b0, 1'b0);
    check("left_const", vec_out, {32'h00000010, 32'h000FFFF0, 32'h23456780, 32'h00000010});

    vall = '1;
    run_cmd(vall, 4'b0101, 5'd31, 2'b01, 1'b0, 1'b1);
    check("right_const", vec_out, {32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000001});

    run_cmd(v1, 4'b1111, 5'd0, 2'b11, 1'b1, 1'b0);
    check("amt0_const", vec_out, v1);

    // Reset in the second cycle of RUN discards the command.
    vec_in       = v1;
    lane_mask    = 4'b1111;
    shift_amount = 5'd1;
    type_op      = 2'b00;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_quiet("arst");
    check("arst_vec", vec_out, '0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_quiet("arst_hold");
    end
    reset = 1'b0;
    run_cmd(v1, 4'b1010, 5'd8, 2'b10, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      logic [VW-1:0]    rv;
      logic [LANES-1:0] rm;
      logic [4:0]       ra;
      logic [1:0]       rt;
      int unsigned      gap;
      for (int i = 0; i < LANES; i++) rv[32*i +: 32] = $urandom();
      rm  = LANES'($urandom());
      ra  = 5'($urandom());
      rt  = 2'($urandom());
      run_cmd(rv, rm, ra, rt, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < int'(gap); g++) begin
        randomize_inputs();
        @(posedge clk); #1;
        check_quiet("gap");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_vec_ctrl.md
# shift_vec_ctrl

Sequencing controller that time-multiplexes the single 32-bit shift unit across a vector of LANES elements. It accepts one vector shift command (start pulse, vector, amount, direction, lane mask) and drives the shifter one lane per cycle. It collects the per-lane results into an output register and signals completion with a one-cycle done pulse. It sits in the execute stage between vector decode and writeback, and owns the shifter's inputs exclusively while busy.

## Interface
- LANES, 4, number of 32-bit elements per vector (2..16)
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  command strobe, accepted only in IDLE
- vec_in  in  LANES*32  source vector; lane i = vec_in[32*i+31:32*i]
- lane_mask  in  LANES  1 = shift lane, 0 = pass lane through unchanged
- shift_amount  in  5  shift count 0..31, common to all lanes
- type_op  in  2  0 = logical left; any nonzero value = logical right
- sh_in  out  32  operand to shifter
- sh_amount  out  5  count to shifter
- sh_type  out  2  direction to shifter
- sh_out  in  32  combinational result from shifter (same cycle)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; vec_out is valid
- vec_out  out  LANES*32  result vector, held until next accepted start

## Operation
- States: IDLE, RUN, DONE. Lane counter idx, width clog2(LANES).
- IDLE: start=1 latches vec_in, lane_mask, shift_amount and type_op into command registers. It clears idx to 0, then goes to RUN. With start=0 it stays in IDLE.
- RUN: sh_in = latched lane[idx], sh_amount = latched amount, sh_type = latched type. At the clock edge, result[idx] is loaded as follows:
  - sh_out if mask[idx]=1;
  - latched lane[idx] if mask[idx]=0.
  - The masked lane still consumes its cycle, so latency is fixed.
- RUN, continued: idx increments each cycle. When idx = LANES-1, the FSM goes to DONE after the capture.
- DONE: done=1 for exactly one cycle, then IDLE. vec_out reflects the complete result register.
- start is ignored in RUN and DONE; no queuing. It is accepted again starting from the IDLE cycle after DONE.
- Inputs changing after acceptance have no effect; only the latched copies are used.
- Shift semantics come from the shifter:
  - Vacated bits are zero.
  - Amount 0 returns the operand.
  - No arithmetic right shift.
  - No wrap-around or rotation.
- sh_in, sh_amount and sh_type are driven to 0 in IDLE and DONE. This gives no spurious shifter toggling.
- vec_out updates lane by lane during RUN. Consumers sample it only on done.

## Timing
- Reset (async, any state) gives:
  - state=IDLE, idx=0;
  - busy=0, done=0;
  - vec_out=0, sh_in=0, sh_amount=0, sh_type=0;
  - command registers cleared.
  - An in-flight command is discarded with no done pulse.
- Start accepted at edge T0. RUN occupies cycles T0+1 .. T0+LANES. done=1 in cycle T0+LANES+1.
- Latency is start-to-done = LANES+1 cycles, independent of mask and amount.
- busy=1 during RUN and DONE, and 0 in IDLE.
- Minimum start-to-start interval is LANES+2 cycles.
- All outputs are registered except sh_in, sh_amount and sh_type. Those are decoded from the state and registers, with no combinational path from inputs.
- Reset deassertion is synchronized externally. The first accepted start is at the first edge with reset=0.

## Test plan
- **Left shift:** reset, then start with LANES=4, vec_in = {0x80000001, 0x0000FFFF, 0x12345678, 0x00000001}, mask=4'b1111, amount=4, type_op=0. Required response: done at start+5, vec_out = {0x00000010, 0x000FFFF0, 0x23456780, 0x00000010}, busy high for 5 cycles.
- **Right shift with mask:** type_op=2'b01, amount=31, vec_in all 0xFFFFFFFF, mask=4'b0101. Required response: vec_out lanes 0 and 2 = 0x00000001, lanes 1 and 3 = 0xFFFFFFFF. Latency is still 5.
- **Amount zero and type_op=2'b11:** amount=0, type_op=2'b11. Required response: vec_out == vec_in, and sh_type observed = 2'b11 during RUN.
- **Start while busy:** a second start at start+2 with different data is ignored, and the first result is correct. A start in the cycle after done is accepted and produces its own result.
- **Reset mid-operation:** assert reset at start+2. Required response: all outputs 0 immediately (asynchronous), no done pulse; the next command completes normally.
- **Input stability:** change vec_in, amount and type_op every cycle during RUN. Required response: the result matches the values latched at start.
